// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job sequencer, controller and datapath.
package gcd_pkg;

  localparam int GCD_WIDTH   = 16;
  localparam int GCD_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    WAIT,
    CLEAR
  } gcd_state_e;

endpackage

// File: rtl/gcd_result_slot.sv
// One-entry valid/ready holding register for a finished GCD job result.
module gcd_result_slot
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_err,
  input  logic             load_bypass,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             res_bypass
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             bypass_q, bypass_d;

  // A load never meets a pending entry: the sequencer only starts a job with the slot empty.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    err_d    = err_q;
    bypass_d = bypass_q;
    if (valid_q && res_ready) begin
      valid_d  = 1'b0;
      data_d   = '0;
      err_d    = 1'b0;
      bypass_d = 1'b0;
    end
    if (load) begin
      valid_d  = 1'b1;
      data_d   = load_data;
      err_d    = load_err;
      bypass_d = load_bypass;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      bypass_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      err_q    <= err_d;
      bypass_q <= bypass_d;
    end
  end

  assign res_valid  = valid_q;
  assign res_data   = data_q;
  assign res_err    = err_q;
  assign res_bypass = bypass_q;

endmodule

// File: rtl/gcd_job_sequencer.sv
// Serialises operand pairs onto the GCD core, collects the result, and
// short-circuits zero operands and hung jobs.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  output logic             core_clr,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             res_bypass
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic             accept;
  logic             ld;
  logic [WIDTH-1:0] ld_data;
  logic             ld_err;
  logic             ld_bypass;

  assign in_ready = !rst && (state_q == IDLE) && !res_valid;
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    ld        = 1'b0;
    ld_data   = '0;
    ld_err    = 1'b0;
    ld_bypass = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d = in_a;
          b_d = in_b;
          // The subtractive core never terminates on a zero operand; gcd(x,0)=x.
          if (in_a == '0 || in_b == '0) begin
            ld        = 1'b1;
            ld_data   = in_a | in_b;
            ld_bypass = 1'b1;
          end else begin
            state_d = LOAD_A;
          end
        end
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // core_done takes priority over a timeout landing on the same cycle.
        if (core_done) begin
          ld      = 1'b1;
          ld_data = core_result;
          state_d = CLEAR;
        end else if (cnt_inc == CNT_MAX) begin
          ld      = 1'b1;
          ld_err  = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    a_q <= a_d;
    b_q <= b_d;
  end

  // Core-facing outputs decode registered state and operands only.
  always_comb begin
    core_start = (state_q == LOAD_A);
    core_clr   = (state_q == CLEAR);
    core_data  = '0;
    case (state_q)
      LOAD_A:       core_data = a_q;
      LOAD_B, WAIT: core_data = b_q;
      default:      core_data = '0;
    endcase
  end

  gcd_result_slot #(
    .WIDTH(WIDTH)
  ) u_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (ld),
    .load_data  (ld_data),
    .load_err   (ld_err),
    .load_bypass(ld_bypass),
    .res_ready  (res_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_err    (res_err),
    .res_bypass (res_bypass)
  );

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Scoreboard bench for gcd_job_sequencer with a behavioural GCD core stub.
module tb_gcd_job_sequencer;

  localparam int W  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         core_start;
  logic [W-1:0] core_data;
  logic         core_clr;
  logic         core_done = 1'b0;
  logic [W-1:0] core_result = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         res_err;
  logic         res_bypass;

  always #5 clk = ~clk;

  gcd_job_sequencer #(
    .WIDTH  (W),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .core_start (core_start),
    .core_data  (core_data),
    .core_clr   (core_clr),
    .core_done  (core_done),
    .core_result(core_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .res_bypass (res_bypass)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
    logic         byp;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat;
    bit           stale;
  } job_t;

  res_t exp_q[$];
  job_t job_q[$];
  int   checks = 0;
  int   passes = 0;
  int   start_cnt = 0;
  int   clr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Core stub: latches A on start, B next cycle, raises done after lat WAIT cycles.
  job_t cur;
  bit   active = 0;
  int   phase = 0;
  int   wcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      active      = 0;
      core_done   = 1'b0;
      core_result = '0;
    end else if (core_start) begin
      start_cnt++;
      if (job_q.size() == 0) begin
        checks++;
        $display("FAIL core_start_unexpected: start with core_data=%0d, no job queued", core_data);
      end else begin
        cur = job_q.pop_front();
        chk("core_data_a", core_data, cur.a);
        active = 1;
        phase  = 1;
        wcnt   = 0;
        if (cur.stale) begin
          core_done   = 1'b1;
          core_result = 16'hDEAD;
        end
      end
    end else if (core_clr) begin
      clr_cnt++;
      core_done = 1'b0;
      active    = 0;
    end else if (active) begin
      if (phase == 1) begin
        chk("core_data_b", core_data, cur.b);
        phase = 2;
      end else begin
        wcnt++;
        chk("core_data_hold", core_data, cur.b);
        if (cur.lat != 0 && wcnt == cur.lat) begin
          core_done   = 1'b1;
          core_result = cur.res;
        end else begin
          core_done = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every delivered result against the scoreboard in order.
  res_t got, want;
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      got = {res_data, res_err, res_bypass};
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL result_unexpected: got data=%0d err=%0d bypass=%0d, none expected",
                 res_data, res_err, res_bypass);
      end else begin
        want = exp_q.pop_front();
        chk("result", 32'(got), 32'(want));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input int lat, input bit stale);
    job_t j;
    j.a = a; j.b = b; j.res = res; j.lat = lat; j.stale = stale;
    job_q.push_back(j);
    if (lat == 0) exp_q.push_back({16'd0, 1'b1, 1'b0});
    else          exp_q.push_back({res, 1'b0, 1'b0});
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Returns the cycle (1 = first cycle after accept) in which res_valid appears.
  task automatic wait_res(output int n);
    n = 1;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      checks++;
      $display("FAIL wait_res_timeout: res_valid=0 after %0d cycles, required 1", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0, c0;

    // Reset
    rst = 1'b1;
    tick(3);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_outputs", {core_start, core_clr, res_err, res_bypass}, 0);
    chk("rst_data", {core_data, res_data}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // 1: 48,18 -> 6 after 7 WAIT cycles
    s0 = start_cnt; c0 = clr_cnt;
    push_job(16'd48, 16'd18, 16'd6, 7, 0);
    send(16'd48, 16'd18);
    wait_res(n);
    chk("t1_latency", n, 10);
    chk("t1_res_data", res_data, 6);
    tick(2);
    chk("t1_starts", start_cnt - s0, 1);
    chk("t1_clears", clr_cnt - c0, 1);
    chk("t1_idle_ready", in_ready, 1);

    // 2: zero-operand bypass
    s0 = start_cnt;
    exp_q.push_back({16'd35, 1'b0, 1'b1});
    send(16'd0, 16'd35);
    wait_res(n);
    chk("t2_bypass_latency", n, 1);
    chk("t2_bypass_flag", res_bypass, 1);
    exp_q.push_back({16'd0, 1'b0, 1'b1});
    send(16'd0, 16'd0);
    wait_res(n);
    chk("t2_zero_zero_latency", n, 1);
    tick(2);
    chk("t2_no_start", start_cnt - s0, 0);

    // 3: result held under back-pressure
    res_ready = 1'b0;
    push_job(16'd270, 16'd192, 16'd6, 5, 0);
    send(16'd270, 16'd192);
    wait_res(n);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", res_valid, 1);
      chk("t3_hold_data", res_data, 6);
      chk("t3_hold_in_ready", in_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("t3_released_valid", res_valid, 0);
    chk("t3_released_in_ready", in_ready, 1);

    // 4: timeout abort, then done coinciding with the timeout cycle
    c0 = clr_cnt;
    push_job(16'd7, 16'd3, 16'd0, 0, 0);
    send(16'd7, 16'd3);
    wait_res(n);
    chk("t4_timeout_latency", n, 11);
    chk("t4_err", res_err, 1);
    chk("t4_data", res_data, 0);
    tick(2);
    chk("t4_clears", clr_cnt - c0, 1);
    chk("t4_idle_ready", in_ready, 1);
    push_job(16'd9, 16'd6, 16'd3, TO, 0);
    send(16'd9, 16'd6);
    wait_res(n);
    chk("t4_done_wins_err", res_err, 0);
    chk("t4_done_wins_data", res_data, 3);
    tick(2);

    // 5: reset during WAIT drops the job
    begin
      job_t j;
      j.a = 16'd100; j.b = 16'd75; j.res = 16'd25; j.lat = 7; j.stale = 0;
      job_q.push_back(j);
    end
    send(16'd100, 16'd75);
    tick(4);
    rst = 1'b1;
    tick();
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_res_valid", res_valid, 0);
    chk("t5_rst_ctrl", {core_start, core_clr, res_err, res_bypass}, 0);
    chk("t5_rst_data", {core_data, res_data}, 0);
    rst = 1'b0;
    #1;
    chk("t5_post_rst_in_ready", in_ready, 1);
    push_job(16'd12, 16'd8, 16'd4, 3, 0);
    send(16'd12, 16'd8);
    wait_res(n);
    chk("t5_after_rst_latency", n, 6);
    chk("t5_after_rst_data", res_data, 4);
    tick(2);

    // 6: back-to-back jobs, stale done during job 3 loads
    s0 = start_cnt;
    push_job(16'd12, 16'd8, 16'd4, 3, 0);
    send(16'd12, 16'd8);
    exp_q.push_back({16'd9, 1'b0, 1'b1});
    send(16'd0, 16'd9);
    push_job(16'd17, 16'd5, 16'd1, 4, 1);
    send(16'd17, 16'd5);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick(2);
    chk("t6_results_drained", exp_q.size(), 0);
    chk("t6_jobs_drained", job_q.size(), 0);
    chk("t6_starts", start_cnt - s0, 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
